// File: rtl/latch_load_ctrl.sv
// -----------------------------------------------------------------------------
// latch_load_ctrl
//
// Write controller for a level-sensitive latch bank (dlatch). A word comes in
// over a valid/ready handshake. The load is then run in three timed phases:
//   SETUP : d is stable and en is low       (SETUP_CYC cycles)
//   OPEN  : en is high                      (OPEN_CYC cycles)
//   HOLD  : d is stable after en falls      (HOLD_CYC cycles)
// When HOLD ends, done pulses for one cycle in the first IDLE cycle. A new
// word can be accepted in that same cycle.
//
// Optional feature, controlled by the macro LATCH_READBACK_EN:
//   On the last HOLD cycle the latch outputs q are compared with d. The
//   result is registered into err at the same edge that raises done. err holds
//   its value until the next transfer edge or until reset.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   request carries a word
//   in_ready  out  controller is IDLE and can accept a word
//   in_data   in   word to load [WIDTH]
//   d         out  latch data, registered [WIDTH]
//   en        out  latch enable, straight from a flop (glitch-free)
//   busy      out  high in SETUP, OPEN and HOLD
//   done      out  one-cycle pulse on load completion
//   q         in   latch outputs for readback [WIDTH]  (LATCH_READBACK_EN)
//   err       out  readback mismatch flag             (LATCH_READBACK_EN)
// -----------------------------------------------------------------------------
module latch_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             busy,
  output logic             done
`ifdef LATCH_READBACK_EN
  ,
  input  logic [WIDTH-1:0] q,
  output logic             err
`endif
);

  // The phase counter must hold the largest phase length minus one.
  localparam int MAX_A   = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic [WIDTH-1:0]   d_reg,     d_next;
  logic               en_reg,    en_next;
  logic               done_reg,  done_next;

  logic               transfer;
  logic               cnt_zero;

  assign transfer = in_valid && (state_reg == IDLE);
  assign cnt_zero = (cnt_reg == '0);

  // State and output registers. The asynchronous reset drops en immediately
  // and abandons any load in progress without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      d_reg     <= '0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      en_reg    <= en_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic. en is set and cleared on the phase transitions, so it
  // is high exactly while the FSM sits in OPEN.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    en_next    = en_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (transfer) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          d_next     = in_data;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_next = OPEN;
          cnt_next   = OPEN_LD;
          en_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      OPEN: begin
        if (cnt_zero) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          en_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
      end
    endcase
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign d        = d_reg;
  assign en       = en_reg;
  assign done     = done_reg;

`ifdef LATCH_READBACK_EN
  logic err_reg, err_next;

  // The compare happens on the last HOLD cycle. By then en has been closed
  // for HOLD_CYC cycles, so q shows the value the latch actually kept.
  always_comb begin
    err_next = err_reg;
    if (transfer) begin
      err_next = 1'b0;
    end else if ((state_reg == HOLD) && cnt_zero) begin
      err_next = (q != d_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_latch_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_load_ctrl
//
// Bench for latch_load_ctrl with WIDTH=8, SETUP=1, OPEN=2, HOLD=1. The
// reference model tracks only the last accepted word and the number of edges
// since it was accepted ("age"). Every expected output follows from that age
// using the phase lengths. A simple latch model with an optional stuck-at-0
// mask drives q when LATCH_READBACK_EN is defined.
// -----------------------------------------------------------------------------
module tb_latch_load_ctrl;

  localparam int S = 1;
  localparam int O = 2;
  localparam int H = 1;
  localparam int T = S + O + H;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] d;
  logic       en;
  logic       busy;
  logic       done;
`ifdef LATCH_READBACK_EN
  logic [7:0] q;
  logic       err;
`endif

  logic [7:0] stuck_mask = 8'h00;
  logic [7:0] q_lat      = 8'h00;

  int checks = 0;
  int errors = 0;
  int loads  = 0;

  // Reference model state
  bit         m_loaded = 0;
  int         m_age    = 0;
  logic [7:0] m_d      = 8'h00;
  bit         m_err    = 0;

  latch_load_ctrl #(
    .WIDTH    (8),
    .SETUP_CYC(S),
    .OPEN_CYC (O),
    .HOLD_CYC (H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .d       (d),
    .en      (en),
    .busy    (busy),
    .done    (done)
`ifdef LATCH_READBACK_EN
    ,
    .q       (q),
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latch bank model: transparent while en is high; masked bits read as 0.
  always_latch begin
    if (en) q_lat <= d & ~stuck_mask;
  end
`ifdef LATCH_READBACK_EN
  assign q = q_lat;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the model's age since the last transfer.
  task automatic check_all();
    bit act;
    act = m_loaded && (m_age < T);
    chk("in_ready", {31'd0, in_ready}, {31'd0, !act});
    chk("busy",     {31'd0, busy},     {31'd0, act});
    chk("en",       {31'd0, en},       {31'd0, m_loaded && (m_age >= S) && (m_age < S + O)});
    chk("done",     {31'd0, done},     {31'd0, m_loaded && (m_age == T)});
    chk("d",        {24'd0, d},        {24'd0, m_d});
`ifdef LATCH_READBACK_EN
    chk("err",      {31'd0, err},      {31'd0, m_err});
`endif
  endtask

  // One clock cycle: drive inputs, step the model at the edge, then check the
  // DUT mid-cycle on the falling edge.
  task automatic tick(input logic v, input logic [7:0] x);
    in_valid = v;
    in_data  = x;
    @(posedge clk);
    if (!(m_loaded && (m_age < T)) && v) begin
      m_loaded = 1;
      m_age    = 0;
      m_d      = x;
      m_err    = 0;
      loads++;
      $display("load %0d accepted data=%02h t=%0t", loads, x, $time);
    end else if (m_loaded) begin
      if (m_age == T - 1) m_err = ((m_d & ~stuck_mask) != m_d);
      if (m_age < 1000) m_age++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    m_loaded = 0;
    m_age    = 0;
    m_d      = 8'h00;
    m_err    = 0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state, checked while rst is still high
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // Single load with backpressure, then a back-to-back load
    tick(1'b1, 8'hA5);
    chk("single_d", {24'd0, d}, 32'h0000_00A5);
    tick(1'b1, 8'hFF);
    chk("open_en1", {31'd0, en}, 32'd1);
    tick(1'b1, 8'hFF);
    chk("open_en2", {31'd0, en}, 32'd1);
    tick(1'b1, 8'hFF);
    chk("bp_d", {24'd0, d}, 32'h0000_00A5);
    tick(1'b1, 8'h3C);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_d", {24'd0, d}, 32'h0000_00A5);
    tick(1'b1, 8'h3C);
    chk("b2b_d", {24'd0, d}, 32'h0000_003C);
    for (int i = 0; i < 6; i++) tick(1'b0, 8'h00);

    // Reset asserted mid-OPEN
    tick(1'b1, 8'hC3);
    tick(1'b0, 8'h00);
    chk("pre_rst_en", {31'd0, en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_en_async", {31'd0, en}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      tick(($urandom_range(0, 2) != 0), 8'($urandom));
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 8'h00);

`ifdef LATCH_READBACK_EN
    // Randomized traffic against a latch with random stuck bits
    stuck_mask = 8'($urandom) | 8'h01;
    for (int i = 0; i < 150; i++) begin
      tick(($urandom_range(0, 2) != 0), 8'($urandom));
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 8'h00);

    // Readback, healthy latch
    stuck_mask = 8'h00;
    tick(1'b1, 8'h5A);
    for (int i = 0; i < T; i++) tick(1'b0, 8'h00);
    chk("rb_ok_done", {31'd0, done}, 32'd1);
    chk("rb_ok_err", {31'd0, err}, 32'd0);

    // Readback, bit0 stuck at 0
    stuck_mask = 8'h01;
    tick(1'b1, 8'h01);
    for (int i = 0; i < T; i++) tick(1'b0, 8'h00);
    chk("rb_stuck_done", {31'd0, done}, 32'd1);
    chk("rb_stuck_err", {31'd0, err}, 32'd1);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    chk("rb_err_hold", {31'd0, err}, 32'd1);
    tick(1'b1, 8'h02);
    chk("rb_err_clear", {31'd0, err}, 32'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
